serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_arith_pkg.sv | 17 +
 rtl/full_subtractor.sv | 23 ++
 rtl/serial_subtractor.sv | 110 +++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic units.
// FSM state encoding, default operand width and counter sizing.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor built from gate primitives.
// d = x^y^bin, bout = ~x&y | ~x&bin | y&bin.
module full_subtractor (
    output logic d,
    output logic bout,
    input  logic x,
    input  logic y,
    input  logic bin
);

    logic nx;
    logic t1;
    logic t2;
    logic t3;

    xor g_d  (d, x, y, bin);
    not g_nx (nx, x);
    and g_t1 (t1, nx, y);
    and g_t2 (t2, nx, bin);
    and g_t3 (t3, y, bin);
    or  g_bo (bout, t1, t2, t3);

endmodule

// File: rtl/serial_subtractor.sv
// LSB-first bit-serial subtractor producing a-b in WIDTH clocks.
// Define SERIAL_SUB_OVERFLOW_EN to add the signed overflow output.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] xs;
    logic [WIDTH-1:0] ys;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             bin;
    logic             d;
    logic             bout;

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic amsb;
    logic bmsb;
`endif

    full_subtractor u_fs (
        .d    (d),
        .bout (bout),
        .x    (xs[0]),
        .y    (ys[0]),
        .bin  (bin)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            xs         <= '0;
            ys         <= '0;
            res        <= '0;
            cnt        <= '0;
            bin        <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            amsb       <= 1'b0;
            bmsb       <= 1'b0;
            overflow   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        xs    <= a;
                        ys    <= b;
                        bin   <= 1'b0;
                        cnt   <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        amsb  <= a[WIDTH-1];
                        bmsb  <= b[WIDTH-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    res <= {d, res[WIDTH-1:1]};
                    xs  <= xs >> 1;
                    ys  <= ys >> 1;
                    bin <= bout;
                    cnt <= cnt + CW'(1);
                    // final step: publish the completed word and borrow
                    if (cnt == LAST) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        diff       <= {d, res[WIDTH-1:1]};
                        borrow_out <= bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        overflow   <= (amsb != bmsb) && (d != amsb);
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
